// File: rtl/caliptra_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of the Caliptra APB slave port.
// Optional downstream wait-state watchdog: define CALIPTRA_APB_ARB_TIMEOUT_EN.
module caliptra_apb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              core_clk,
  input  logic              cptra_rst_b,

  input  logic              r0_psel,
  input  logic              r0_penable,
  input  logic              r0_pwrite,
  input  logic [ADDR_W-1:0] r0_paddr,
  input  logic [2:0]        r0_pprot,
  input  logic [DATA_W-1:0] r0_pwdata,
  output logic [DATA_W-1:0] r0_prdata,
  output logic              r0_pready,
  output logic              r0_pslverr,

  input  logic              r1_psel,
  input  logic              r1_penable,
  input  logic              r1_pwrite,
  input  logic [ADDR_W-1:0] r1_paddr,
  input  logic [2:0]        r1_pprot,
  input  logic [DATA_W-1:0] r1_pwdata,
  output logic [DATA_W-1:0] r1_prdata,
  output logic              r1_pready,
  output logic              r1_pslverr,

  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [2:0]        PPROT,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,

  output logic              timeout_pulse,
  output logic              gnt_id
);

  // state  | meaning
  // IDLE   | no transfer in flight; arbitrate between r0_psel/r1_psel
  // SETUP  | downstream setup phase (PSEL=1, PENABLE=0)
  // ACCESS | downstream access phase, waiting for PREADY (or watchdog)
  // RESP   | one-cycle rN_pready pulse to the granted requester
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state;
  logic              last_gnt;
  logic              pick;
  logic              sel_pwrite;
  logic [ADDR_W-1:0] sel_paddr;
  logic [2:0]        sel_pprot;
  logic [DATA_W-1:0] sel_pwdata;
  logic              wdog_exp;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  // Requester penable carries no information for arbitration.
  logic unused_penable;
  assign unused_penable = r0_penable ^ r1_penable;

  always_comb begin
    pick = 1'b0;
    if (r0_psel && r1_psel) begin
      pick = ~last_gnt;
    end else if (r1_psel) begin
      pick = 1'b1;
    end
    sel_pwrite = pick ? r1_pwrite : r0_pwrite;
    sel_paddr  = pick ? r1_paddr  : r0_paddr;
    sel_pprot  = pick ? r1_pprot  : r0_pprot;
    sel_pwdata = pick ? r1_pwdata : r0_pwdata;
  end

  // A watchdog expiry completes as an error with zeroed read data.
  assign rsp_err  = PREADY ? PSLVERR : 1'b1;
  assign rsp_data = (!PREADY || PWRITE) ? '0 : PRDATA;

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;

  assign wdog_exp = (state == ACCESS) && !PREADY && (wdog == WD_LAST);

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      wdog <= '0;
    end else if (state == SETUP) begin
      wdog <= '0;
    end else if (state == ACCESS && !PREADY && !wdog_exp) begin
      wdog <= wdog + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wdog_exp = 1'b0;
`endif

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state         <= IDLE;
      last_gnt      <= 1'b1;
      gnt_id        <= 1'b0;
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PPROT         <= '0;
      PWDATA        <= '0;
      r0_prdata     <= '0;
      r0_pready     <= 1'b0;
      r0_pslverr    <= 1'b0;
      r1_prdata     <= '0;
      r1_pready     <= 1'b0;
      r1_pslverr    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      r0_pready     <= 1'b0;
      r0_pslverr    <= 1'b0;
      r1_pready     <= 1'b0;
      r1_pslverr    <= 1'b0;
      timeout_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (r0_psel || r1_psel) begin
            gnt_id   <= pick;
            last_gnt <= pick;
            PWRITE   <= sel_pwrite;
            PADDR    <= sel_paddr;
            PPROT    <= sel_pprot;
            PWDATA   <= sel_pwdata;
            PSEL     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || wdog_exp) begin
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            timeout_pulse <= !PREADY;
            if (gnt_id) begin
              r1_pready  <= 1'b1;
              r1_pslverr <= rsp_err;
              r1_prdata  <= rsp_data;
            end else begin
              r0_pready  <= 1'b1;
              r0_pslverr <= rsp_err;
              r0_prdata  <= rsp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_caliptra_apb_arbiter.sv
// Scoreboard bench for caliptra_apb_arbiter: queued requesters, a wait-state slave model,
// and monitors that pop expected downstream setups and requester responses.
module tb_caliptra_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  prot;
    int          lat;
  } xfer_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } rsp_t;

  logic          core_clk = 1'b0;
  logic          cptra_rst_b = 1'b0;
  logic          r0_psel, r0_penable, r0_pwrite;
  logic [AW-1:0] r0_paddr;
  logic [2:0]    r0_pprot;
  logic [DW-1:0] r0_pwdata, r0_prdata;
  logic          r0_pready, r0_pslverr;
  logic          r1_psel, r1_penable, r1_pwrite;
  logic [AW-1:0] r1_paddr;
  logic [2:0]    r1_pprot;
  logic [DW-1:0] r1_pwdata, r1_prdata;
  logic          r1_pready, r1_pslverr;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          timeout_pulse, gnt_id;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int issue_cyc [2];

  xfer_t req_q0 [$];
  xfer_t req_q1 [$];
  xfer_t exp_dn [$];
  rsp_t  exp_rsp [$];

  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;

  caliptra_apb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .core_clk(core_clk), .cptra_rst_b(cptra_rst_b),
    .r0_psel(r0_psel), .r0_penable(r0_penable), .r0_pwrite(r0_pwrite),
    .r0_paddr(r0_paddr), .r0_pprot(r0_pprot), .r0_pwdata(r0_pwdata),
    .r0_prdata(r0_prdata), .r0_pready(r0_pready), .r0_pslverr(r0_pslverr),
    .r1_psel(r1_psel), .r1_penable(r1_penable), .r1_pwrite(r1_pwrite),
    .r1_paddr(r1_paddr), .r1_pprot(r1_pprot), .r1_pwdata(r1_pwdata),
    .r1_prdata(r1_prdata), .r1_pready(r1_pready), .r1_pslverr(r1_pslverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PPROT(PPROT), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .timeout_pulse(timeout_pulse), .gnt_id(gnt_id)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_xfer(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic write, input logic [2:0] prot, input int slat,
                           input logic has_rsp, input logic [31:0] rdata, input logic err,
                           input logic tmo, input int rlat);
    xfer_t x;
    rsp_t  r;
    x = '{id: id, addr: addr, wdata: wdata, write: write, prot: prot, lat: slat};
    if (id == 0) req_q0.push_back(x);
    else req_q1.push_back(x);
    exp_dn.push_back(x);
    if (has_rsp) begin
      r = '{id: id, rdata: rdata, err: err, tmo: tmo, lat: rlat};
      exp_rsp.push_back(r);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_dn.size() != 0 || exp_rsp.size() != 0 || req_q0.size() != 0 ||
            req_q1.size() != 0) && n < budget) begin
      @(negedge core_clk);
      n++;
    end
    chk("drain_in_budget", (n < budget), 1'b1);
    repeat (3) @(negedge core_clk);
  endtask

  // Requester drivers: hold each request until its pready pulse, abandon on reset.
  initial begin : drv
    logic  fin0, fin1, busy0, busy1;
    xfer_t it;
    busy0 = 1'b0; busy1 = 1'b0;
    r0_psel = 1'b0; r0_penable = 1'b0; r0_pwrite = 1'b0; r0_paddr = '0; r0_pprot = '0; r0_pwdata = '0;
    r1_psel = 1'b0; r1_penable = 1'b0; r1_pwrite = 1'b0; r1_paddr = '0; r1_pprot = '0; r1_pwdata = '0;
    forever begin
      @(negedge core_clk);
      fin0 = r0_pready;
      fin1 = r1_pready;
      @(posedge core_clk);
      #1;
      if (!cptra_rst_b) begin
        busy0 = 1'b0; busy1 = 1'b0;
        r0_psel = 1'b0; r0_penable = 1'b0;
        r1_psel = 1'b0; r1_penable = 1'b0;
      end else begin
        if (busy0 && fin0) busy0 = 1'b0;
        if (!busy0 && req_q0.size() != 0) begin
          it = req_q0.pop_front();
          busy0 = 1'b1;
          r0_paddr = it.addr; r0_pwdata = it.wdata; r0_pwrite = it.write; r0_pprot = it.prot;
          r0_psel = 1'b1; r0_penable = 1'b0;
          issue_cyc[0] = cyc;
        end else if (busy0) begin
          r0_penable = 1'b1;
        end else begin
          r0_psel = 1'b0; r0_penable = 1'b0;
        end
        if (busy1 && fin1) busy1 = 1'b0;
        if (!busy1 && req_q1.size() != 0) begin
          it = req_q1.pop_front();
          busy1 = 1'b1;
          r1_paddr = it.addr; r1_pwdata = it.wdata; r1_pwrite = it.write; r1_pprot = it.prot;
          r1_psel = 1'b1; r1_penable = 1'b0;
          issue_cyc[1] = cyc;
        end else if (busy1) begin
          r1_penable = 1'b1;
        end else begin
          r1_psel = 1'b0; r1_penable = 1'b0;
        end
      end
    end
  end

  // Slave model: slv_wait wait states per access, then PREADY with slv_rdata/slv_err.
  initial begin : slave
    int wcnt;
    wcnt = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge core_clk);
      PRDATA  = slv_rdata;
      PSLVERR = slv_err;
      if (cptra_rst_b && PSEL && PENABLE) begin
        if (wcnt < slv_wait) begin
          PREADY = 1'b0;
          wcnt++;
        end else begin
          PREADY = 1'b1;
        end
      end else begin
        PREADY = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin : mon_dn
    xfer_t e;
    forever begin
      @(negedge core_clk);
      if (cptra_rst_b && PSEL && !PENABLE) begin
        if (exp_dn.size() == 0) begin
          chk("dn_unexpected_setup", PADDR, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_dn.pop_front();
          chk("dn_gnt_id", gnt_id, e.id[0]);
          chk("dn_paddr", PADDR, e.addr);
          chk("dn_pwdata", PWDATA, e.wdata);
          chk("dn_pwrite", PWRITE, e.write);
          chk("dn_pprot", PPROT, e.prot);
          if (e.lat >= 0) chk("dn_setup_latency", cyc - issue_cyc[e.id], e.lat);
        end
      end
    end
  end

  initial begin : mon_rsp
    rsp_t e;
    forever begin
      @(negedge core_clk);
      if (r0_pready || r1_pready) begin
        rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {r1_pready, r0_pready}, 2'b00);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_id", {r1_pready, r0_pready}, (e.id == 1) ? 2'b10 : 2'b01);
          chk("rsp_prdata", (e.id == 1) ? r1_prdata : r0_prdata, e.rdata);
          chk("rsp_pslverr", (e.id == 1) ? r1_pslverr : r0_pslverr, e.err);
          chk("rsp_timeout_pulse", timeout_pulse, e.tmo);
          if (e.lat >= 0) chk("rsp_latency", cyc - issue_cyc[e.id], e.lat);
        end
      end
    end
  end

  initial begin : main
    int n;
    int rsp_before;
    repeat (3) @(negedge core_clk);
    chk("reset_ctrl_outputs",
        {PSEL, PENABLE, r0_pready, r1_pready, r0_pslverr, r1_pslverr, timeout_pulse, gnt_id}, 8'h00);
    chk("reset_prdata", {r0_prdata, r1_prdata}, 64'h0);
    cptra_rst_b = 1'b1;

    // Simultaneous requests at reset exit: r0 wins the first tie, r1 setup at T+5.
    slv_rdata = 32'h1234_5678;
    push_xfer(0, 32'h3000_0010, 32'h0, 1'b0, 3'd1, 1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 3);
    push_xfer(1, 32'h3000_0020, 32'h0, 1'b0, 3'd2, 5, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 7);
    drain(40);

    // Single zero-wait read.
    slv_rdata = 32'hDEAD_BEEF;
    push_xfer(0, 32'h3000_0000, 32'h0, 1'b0, 3'd0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    drain(40);

    // Back-to-back writes from both sides; r0 was granted last, so r1 leads.
    slv_rdata = 32'h7777_7777;
    for (int i = 0; i < 6; i++) begin
      push_xfer(1, 32'h2000_0000 + 32'(i * 4), 32'hB1B1_0000 + 32'(i), 1'b1, 3'(i), -1,
                1'b1, 32'h0, 1'b0, 1'b0, -1);
      push_xfer(0, 32'h1000_0000 + 32'(i * 4), 32'hA0A0_0000 + 32'(i), 1'b1, 3'(7 - i), -1,
                1'b1, 32'h0, 1'b0, 1'b0, -1);
    end
    drain(200);

    // r1 write with 3 wait states and a slave error.
    slv_wait = 3; slv_err = 1'b1;
    push_xfer(1, 32'h3000_0040, 32'hCAFE_F00D, 1'b1, 3'd3, 1, 1'b1, 32'h0, 1'b1, 1'b0, 6);
    drain(40);
    slv_wait = 0; slv_err = 1'b0;

    // Slave that never answers.
    slv_wait = 1000;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
    slv_rdata = 32'hFFFF_FFFF;
    push_xfer(0, 32'h3000_0200, 32'h0, 1'b0, 3'd4, 1, 1'b1, 32'h0, 1'b1, 1'b1, 10);
    n = 0;
    do begin
      @(negedge core_clk);
      n++;
    end while (!r0_pready && n < 50);
    chk("tmo_pready_seen", r0_pready, 1'b1);
    chk("tmo_psel_dropped", {PSEL, PENABLE}, 2'b00);
    drain(40);
    slv_wait = 0;
`else
    slv_rdata = 32'h5A5A_0001;
    rsp_before = rsp_cnt;
    push_xfer(0, 32'h3000_0200, 32'h0, 1'b0, 3'd4, 1, 1'b1, 32'h5A5A_0001, 1'b0, 1'b0, -1);
    repeat (100) @(negedge core_clk);
    chk("hang_still_access", {PSEL, PENABLE}, 2'b11);
    chk("hang_no_response", rsp_cnt - rsp_before, 0);
    chk("hang_no_timeout_pulse", timeout_pulse, 1'b0);
    slv_wait = 0;
    drain(40);
`endif

    // Reset during ACCESS abandons the transfer; r1 then completes normally.
    slv_wait = 1000;
    rsp_before = rsp_cnt;
    push_xfer(0, 32'h3000_0080, 32'h0, 1'b0, 3'd5, 1, 1'b0, 32'h0, 1'b0, 1'b0, -1);
    n = 0;
    do begin
      @(negedge core_clk);
      n++;
    end while (!(PSEL && PENABLE) && n < 20);
    chk("rst_reached_access", (PSEL && PENABLE), 1'b1);
    #2 cptra_rst_b = 1'b0;
    #1;
    chk("rst_async_drop", {PSEL, PENABLE, r0_pready, r1_pready}, 4'b0000);
    chk("rst_gnt_id", gnt_id, 1'b0);
    repeat (2) @(negedge core_clk);
    slv_wait = 0;
    cptra_rst_b = 1'b1;
    chk("rst_no_response", rsp_cnt - rsp_before, 0);
    slv_rdata = 32'h600D_0001;
    push_xfer(1, 32'h3000_0100, 32'h0, 1'b0, 3'd6, 1, 1'b1, 32'h600D_0001, 1'b0, 1'b0, 3);
    drain(40);

    chk("exp_dn_empty", exp_dn.size(), 0);
    chk("exp_rsp_empty", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_time_limit: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
